// File: rtl/wf_comp_pkg.sv
// Shared constants, coefficient table and state encoding for the waterfall
// CIC droop-compensation stage.
package wf_comp_pkg;

    localparam int unsigned WF_COMP_TAPS = 11;
    localparam int unsigned WF_COMP_HALF = 6;
    localparam int unsigned COEF_W       = 18;
    localparam int unsigned COEF_FRAC    = 16;
    localparam int unsigned ACC_W        = 38;

    // Half of the symmetric impulse response; c[10-k] == c[k], taps sum to 65536.
    localparam logic signed [COEF_W-1:0] WF_COMP_COEF [WF_COMP_HALF] = '{
        -18'sd328, 18'sd656, -18'sd1311, 18'sd2621, -18'sd6554, 18'sd75368
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BYP  = 2'd1,
        ST_MAC  = 2'd2,
        ST_RND  = 2'd3
    } wf_comp_state_e;

endpackage

// File: rtl/wf_comp_mac.sv
// One channel of the compensation FIR: 11-deep delay line, symmetric pre-adder,
// multiplier, 38-bit accumulator, round/saturate and the output register.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   shift_en_i          accept: shift din_i into the delay line, clear acc
//   acc_en_i            accumulate pre-added tap pair k_i
//   fir_ld_i            load rounded/saturated acc into dout_o
//   byp_ld_i            load delay-line head into dout_o
//   k_i                 tap-pair index 0..5
//   din_i / dout_o      signed sample in / registered sample out
module wf_comp_mac #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned COEF_FRAC = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       shift_en_i,
    input  logic                       acc_en_i,
    input  logic                       fir_ld_i,
    input  logic                       byp_ld_i,
    input  logic [2:0]                 k_i,
    input  logic signed [IN_WIDTH-1:0] din_i,
    output logic signed [IN_WIDTH-1:0] dout_o
);
    import wf_comp_pkg::*;

    localparam int unsigned PW = IN_WIDTH + 1;
    localparam int unsigned MW = PW + COEF_W;
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'({1'b0, {(IN_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    logic signed [IN_WIDTH-1:0] x_q [WF_COMP_TAPS];
    logic signed [IN_WIDTH-1:0] x_d [WF_COMP_TAPS];
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [IN_WIDTH-1:0] dout_q, dout_d;

    logic [3:0]                 km_c;
    logic signed [IN_WIDTH-1:0] xa_c, xb_c;
    logic signed [PW-1:0]       pre_c;
    logic signed [COEF_W-1:0]   coef_c;
    logic signed [MW-1:0]       prod_c;
    logic signed [ACC_W-1:0]    rnd_c;
    logic signed [IN_WIDTH-1:0] sat_c;

    // Pre-add mirrored taps (centre tap alone), multiply, round and clip.
    always_comb begin
        km_c   = 4'(WF_COMP_TAPS - 1) - {1'b0, k_i};
        xa_c   = x_q[k_i];
        xb_c   = (k_i == 3'(WF_COMP_HALF - 1)) ? '0 : x_q[km_c];
        pre_c  = PW'(xa_c) + PW'(xb_c);
        coef_c = COEF_W'(WF_COMP_COEF[k_i]);
        prod_c = pre_c * coef_c;
        rnd_c  = (acc_q + RND_HALF) >>> COEF_FRAC;
        if (rnd_c > SAT_MAX) begin
            sat_c = IN_WIDTH'(SAT_MAX);
        end else if (rnd_c < SAT_MIN) begin
            sat_c = IN_WIDTH'(SAT_MIN);
        end else begin
            sat_c = IN_WIDTH'(rnd_c);
        end
    end

    // Next-state for delay line, accumulator and output register.
    always_comb begin
        x_d    = x_q;
        acc_d  = acc_q;
        dout_d = dout_q;
        if (shift_en_i) begin
            x_d[0] = din_i;
            for (int unsigned i = 1; i < WF_COMP_TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + ACC_W'(prod_c);
        end
        if (fir_ld_i) begin
            dout_d = sat_c;
        end else if (byp_ld_i) begin
            dout_d = x_q[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < WF_COMP_TAPS; i++) begin
                x_q[i] <= '0;
            end
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            x_q    <= x_d;
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/wf_cic_comp.sv
// Waterfall CIC droop-compensation stage: sequences a shared 6-step MAC over
// the I and Q channel datapaths, or passes samples straight through in bypass.
// Ports:
//   adc_clk, rst_n        clock, synchronous active-low reset
//   enable                1 = FIR, 0 = bypass (sampled on accept)
//   clr_overrun           pulse clearing the sticky overrun flag
//   in_strobe/in_i/in_q   decimated I/Q sample from the CIC
//   out_strobe/out_i/out_q  one-cycle valid and held I/Q result
//   busy                  state machine not idle
//   overrun               sticky: a strobe arrived while busy and was dropped
module wf_cic_comp #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned COEF_FRAC = 16
) (
    input  logic                       adc_clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clr_overrun,
    input  logic                       in_strobe,
    input  logic signed [IN_WIDTH-1:0] in_i,
    input  logic signed [IN_WIDTH-1:0] in_q,
    output logic                       out_strobe,
    output logic signed [IN_WIDTH-1:0] out_i,
    output logic signed [IN_WIDTH-1:0] out_q,
    output logic                       busy,
    output logic                       overrun
);
    import wf_comp_pkg::*;

    wf_comp_state_e state_q, state_d;
    logic [2:0]     k_q, k_d;
    logic           out_strobe_q, out_strobe_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;
    logic           accept_c, acc_en_c, fir_ld_c, byp_ld_c;

    // Next-state and datapath controls; enable is captured in the BYP/MAC choice.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        overrun_d = overrun_q;
        accept_c  = 1'b0;
        acc_en_c  = 1'b0;
        fir_ld_c  = 1'b0;
        byp_ld_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_strobe) begin
                    accept_c = 1'b1;
                    k_d      = '0;
                    state_d  = enable ? ST_MAC : ST_BYP;
                end
            end
            ST_BYP: begin
                byp_ld_c = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_MAC: begin
                acc_en_c = 1'b1;
                if (k_q == 3'(WF_COMP_HALF - 1)) begin
                    state_d = ST_RND;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_RND: begin
                fir_ld_c = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A dropped strobe wins over a same-cycle clear.
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (in_strobe && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
        out_strobe_d = byp_ld_c | fir_ld_c;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            out_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            out_strobe_q <= out_strobe_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_strobe = out_strobe_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

    wf_comp_mac #(
        .IN_WIDTH  (IN_WIDTH),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC)
    ) u_mac_i (
        .clk_i      (adc_clk),
        .rst_ni     (rst_n),
        .shift_en_i (accept_c),
        .acc_en_i   (acc_en_c),
        .fir_ld_i   (fir_ld_c),
        .byp_ld_i   (byp_ld_c),
        .k_i        (k_q),
        .din_i      (in_i),
        .dout_o     (out_i)
    );

    wf_comp_mac #(
        .IN_WIDTH  (IN_WIDTH),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC)
    ) u_mac_q (
        .clk_i      (adc_clk),
        .rst_ni     (rst_n),
        .shift_en_i (accept_c),
        .acc_en_i   (acc_en_c),
        .fir_ld_i   (fir_ld_c),
        .byp_ld_i   (byp_ld_c),
        .k_i        (k_q),
        .din_i      (in_q),
        .dout_o     (out_q)
    );

endmodule

// File: tb/tb_wf_cic_comp.sv
// Directed bench for wf_cic_comp: bypass, DC gain, impulse response,
// saturation, overrun handling and mid-computation reset.
module tb_wf_cic_comp;

    logic              adc_clk     = 1'b0;
    logic              rst_n       = 1'b0;
    logic              enable      = 1'b0;
    logic              clr_overrun = 1'b0;
    logic              in_strobe   = 1'b0;
    logic signed [15:0] in_i       = '0;
    logic signed [15:0] in_q       = '0;
    logic              out_strobe;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;
    logic              busy;
    logic              overrun;

    int n_chk = 0;
    int n_err = 0;
    int lat;
    int cnt;

    // Expected impulse response for +16384 on I and -16384 on Q.
    int imp_i [11] = '{-82, 164, -328, 655, -1638, 18842, -1638, 655, -328, 164, -82};
    int imp_q [11] = '{82, -164, 328, -655, 1639, -18842, 1639, -655, 328, -164, 82};
    // Step responses for samples 6..11 of a 32767 (I) / -32768 (Q) step.
    int sat_i [6] = '{32767, 31948, 32767, 32603, 32767, 32767};
    int sat_q [6] = '{-32768, -31949, -32768, -32604, -32768, -32768};

    wf_cic_comp #(
        .IN_WIDTH  (16),
        .COEF_W    (18),
        .COEF_FRAC (16)
    ) dut (
        .adc_clk     (adc_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clr_overrun (clr_overrun),
        .in_strobe   (in_strobe),
        .in_i        (in_i),
        .in_q        (in_q),
        .out_strobe  (out_strobe),
        .out_i       (out_i),
        .out_q       (out_q),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    // One-cycle strobe; returns 1 ns after the accepting edge (cycle t+1).
    task automatic send(input int i, input int q, input logic en);
        @(negedge adc_clk);
        in_i      = 16'(i);
        in_q      = 16'(q);
        enable    = en;
        in_strobe = 1'b1;
        @(posedge adc_clk);
        #1;
        in_strobe = 1'b0;
    endtask

    // Waits (bounded) for out_strobe; lat is the cycle offset from the accept cycle.
    task automatic wait_out(input int start, output int l);
        l = start;
        while (out_strobe !== 1'b1 && l < 20) begin
            @(posedge adc_clk);
            #1;
            l++;
        end
    endtask

    task automatic xfer(input string tag, input int i, input int q, input logic en,
                        input int exp_lat, input logic chk_d, input int ei, input int eq);
        int l;
        send(i, q, en);
        wait_out(1, l);
        chk({tag, " latency"}, l, exp_lat);
        if (chk_d) begin
            chk({tag, " out_i"}, out_i, ei);
            chk({tag, " out_q"}, out_q, eq);
        end
    endtask

    task automatic flush_zero(input string tag);
        for (int n = 0; n < 11; n++) begin
            xfer(tag, 0, 0, 1'b1, 8, (n == 10), 0, 0);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge adc_clk);
        #1;
        chk("rst out_strobe", out_strobe, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        chk("rst out_i", out_i, 0);
        chk("rst out_q", out_q, 0);
        rst_n = 1'b1;

        // Bypass
        send(1234, -77, 1'b0);
        chk("byp busy t+1", busy, 1);
        chk("byp strobe t+1", out_strobe, 0);
        wait_out(1, lat);
        chk("byp latency", lat, 2);
        chk("byp out_i", out_i, 1234);
        chk("byp out_q", out_q, -77);
        chk("byp busy t+2", busy, 0);
        @(posedge adc_clk);
        #1;
        chk("byp strobe width", out_strobe, 0);
        chk("byp hold out_i", out_i, 1234);

        // DC gain, back-to-back accepts
        for (int n = 0; n < 11; n++) begin
            xfer("dc", 1000, -1000, 1'b1, 8, (n == 10), 1000, -1000);
        end

        // Impulse response
        flush_zero("imp flush");
        xfer("imp0", 16384, -16384, 1'b1, 8, 1'b1, imp_i[0], imp_q[0]);
        for (int n = 1; n < 11; n++) begin
            xfer($sformatf("imp%0d", n), 0, 0, 1'b1, 8, 1'b1, imp_i[n], imp_q[n]);
        end
        xfer("imp tail", 0, 0, 1'b1, 8, 1'b1, 0, 0);

        // Overrun: second strobe 3 cycles after the first is dropped
        send(16384, 0, 1'b1);
        repeat (2) begin
            @(posedge adc_clk);
            #1;
        end
        in_i      = 16'sd7777;
        in_strobe = 1'b1;
        @(posedge adc_clk);
        #1;
        in_strobe = 1'b0;
        chk("ovr set", overrun, 1);
        wait_out(4, lat);
        chk("ovr latency", lat, 8);
        chk("ovr out_i", out_i, -82);
        xfer("ovr next", 0, 0, 1'b1, 8, 1'b1, 164, 0);
        chk("ovr sticky", overrun, 1);
        @(negedge adc_clk);
        clr_overrun = 1'b1;
        @(posedge adc_clk);
        #1;
        clr_overrun = 1'b0;
        chk("ovr clear", overrun, 0);
        send(0, 0, 1'b1);
        in_strobe   = 1'b1;
        clr_overrun = 1'b1;
        @(posedge adc_clk);
        #1;
        in_strobe   = 1'b0;
        clr_overrun = 1'b0;
        chk("ovr set beats clr", overrun, 1);
        wait_out(2, lat);
        chk("ovr2 latency", lat, 8);
        @(negedge adc_clk);
        clr_overrun = 1'b1;
        @(posedge adc_clk);
        #1;
        clr_overrun = 1'b0;
        chk("ovr clear2", overrun, 0);

        // Saturation on positive and negative steps
        flush_zero("sat flush");
        for (int n = 0; n < 5; n++) begin
            xfer("sat ramp", 32767, -32768, 1'b1, 8, 1'b0, 0, 0);
        end
        for (int n = 0; n < 6; n++) begin
            xfer($sformatf("sat%0d", n + 6), 32767, -32768, 1'b1, 8, 1'b1, sat_i[n], sat_q[n]);
        end

        // Reset during MAC at t+4
        send(1000, 1000, 1'b1);
        repeat (3) begin
            @(posedge adc_clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge adc_clk);
        #1;
        rst_n = 1'b1;
        chk("mrst busy", busy, 0);
        chk("mrst out_i", out_i, 0);
        chk("mrst out_q", out_q, 0);
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            if (out_strobe !== 1'b0) cnt++;
            @(posedge adc_clk);
            #1;
        end
        chk("mrst no strobe", cnt, 0);
        xfer("mrst dc500", 500, -500, 1'b1, 8, 1'b1, -3, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
